// File: rtl/memory_row_ctrl.sv
// memory_row_ctrl: sequences S/op/data lines of a latch-style memory row array for single-word host requests.
// Latency: acceptance edge to rsp_valid is 4 cycles (writes take 7 when MEMCTRL_READBACK_VERIFY_EN is defined).
// Backpressure: one request in flight; req_ready low until the response is taken; rsp_* hold while rsp_ready is low.
module memory_row_ctrl #(
    parameter int ROWS   = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic [ROWS-1:0]       row_sel,
    output logic                  row_op,
    output logic [WIDTH-1:0]      row_din,
    input  logic [ROWS*WIDTH-1:0] row_dout_all
);

    // Row lines are registered from the current state, so they trail the state by one cycle.
    // That lag keeps data ahead of select and select ahead of any op change.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE,
        ST_CAPTURE,
        ST_RESP
`ifdef MEMCTRL_READBACK_VERIFY_EN
        , ST_VSETUP,
        ST_VSTROBE,
        ST_VCAPTURE
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ROWS-1:0]     row_sel_q, row_sel_d;
    logic                row_op_q, row_op_d;
    logic [WIDTH-1:0]    row_din_q, row_din_d;

    logic [ROWS-1:0]     sel_onehot;
    logic [WIDTH-1:0]    row_rdata;
    logic                in_range;

    // Decode the latched address: one-hot select and the addressed row's data (both zero when out of range).
    always_comb begin
        sel_onehot = '0;
        row_rdata  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (32'(addr_q) == 32'(r)) begin
                sel_onehot[r] = 1'b1;
                row_rdata     = row_dout_all[r*WIDTH +: WIDTH];
            end
        end
        in_range = |sel_onehot;
    end

    // Next-state logic and request latching.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP:   state_d = ST_STROBE;
            ST_STROBE:  state_d = write_q ? ST_RELEASE : ST_CAPTURE;
`ifdef MEMCTRL_READBACK_VERIFY_EN
            ST_RELEASE: state_d = ST_VSETUP;
`else
            ST_RELEASE: state_d = ST_RESP;
`endif
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef MEMCTRL_READBACK_VERIFY_EN
            ST_VSETUP:   state_d = ST_VSTROBE;
            ST_VSTROBE:  state_d = ST_VCAPTURE;
            ST_VCAPTURE: state_d = ST_RESP;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    // Registered outputs: row lines from the current state, response captured on entry to the valid phase.
    always_comb begin
        row_sel_d   = '0;
        row_op_d    = 1'b0;
        row_din_d   = row_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready_d = (state_d == ST_IDLE);
        case (state_q)
            ST_SETUP: begin
                row_op_d = write_q;
                if (write_q) begin
                    row_din_d = wdata_q;
                end
            end
            ST_STROBE: begin
                row_sel_d = sel_onehot;
                row_op_d  = write_q;
            end
            ST_RELEASE: row_op_d  = 1'b1;
            ST_CAPTURE: row_sel_d = sel_onehot;
            ST_RESP: begin
                if (!rsp_valid_q) begin
                    // Row select is still asserted this cycle, so row data is sampled here.
                    rsp_valid_d = 1'b1;
`ifdef MEMCTRL_READBACK_VERIFY_EN
                    rsp_rdata_d = row_rdata;
                    rsp_err_d   = !in_range || (write_q && (row_rdata != wdata_q));
`else
                    rsp_rdata_d = write_q ? '0 : row_rdata;
                    rsp_err_d   = !in_range;
`endif
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
`ifdef MEMCTRL_READBACK_VERIFY_EN
            ST_VSTROBE:  row_sel_d = sel_onehot;
            ST_VCAPTURE: row_sel_d = sel_onehot;
`endif
            default: ;
        endcase
    end

    // State and output registers; reset drops row select and op immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            row_sel_q   <= '0;
            row_op_q    <= 1'b0;
            row_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            row_sel_q   <= row_sel_d;
            row_op_q    <= row_op_d;
            row_din_q   <= row_din_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign row_sel   = row_sel_q;
    assign row_op    = row_op_q;
    assign row_din   = row_din_q;

endmodule

// File: tb/tb_memory_row_ctrl.sv
// tb_memory_row_ctrl: drives a 4-row and a 3-row controller in lockstep against a behavioural row array.
// Latency: expected response timing comes from the documented cycle numbering.
// Backpressure: rsp_ready is held low for chosen stretches during the response phase.
module tb_memory_row_ctrl;
`ifdef MEMCTRL_READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int WLAT = VERIFY ? 7 : 4;
    localparam int RLAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_write, rsp_ready;
    logic [1:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready, rsp_valid, rsp_err, row_op;
    logic [7:0]  rsp_rdata, row_din;
    logic [3:0]  row_sel;
    logic [31:0] row_dout_all;
    logic        req_ready3, rsp_valid3, rsp_err3, row_op3;
    logic [7:0]  rsp_rdata3, row_din3;
    logic [2:0]  row_sel3;
    logic [23:0] row_dout_all3;

    logic [7:0]  mem [4];
    logic [7:0]  exp_mem [4];
    logic        stuck;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    memory_row_ctrl #(.ROWS(4), .WIDTH(8), .ADDR_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .row_sel(row_sel), .row_op(row_op), .row_din(row_din), .row_dout_all(row_dout_all)
    );

    memory_row_ctrl #(.ROWS(3), .WIDTH(8), .ADDR_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .row_sel(row_sel3), .row_op(row_op3), .row_din(row_din3), .row_dout_all(row_dout_all3)
    );

    // Behavioural row array: a row stores the data bus while its select and op are both high.
    always @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            if (row_sel[r] && row_op) mem[r] <= row_din;
        end
    end
    assign row_dout_all  = stuck ? 32'h0 : {mem[3], mem[2], mem[1], mem[0]};
    assign row_dout_all3 = row_dout_all[23:0];

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", nm, what, act, exp);
        end
    endtask

    // Select window per transaction kind, in cycles after the acceptance edge.
    function automatic logic [3:0] exp_sel(input int k, input logic w, input int a, input int rows);
        bit on;
        if (w) on = (k == 2) || (VERIFY && (k == 5 || k == 6));
        else   on = (k == 2) || (k == 3);
        if (a >= rows) on = 1'b0;
        return on ? 4'(1 << a) : 4'b0000;
    endfunction

    // Issue one request (called just after a negedge) and follow it through to the response handshake.
    task automatic run_txn(input string nm, input logic w, input logic [1:0] a, input logic [7:0] d,
                           input int hold, input logic [7:0] erd, input logic eerr);
        int         lat, waits;
        logic [7:0] erd3;
        logic       eerr3;
        logic       eop;
        lat   = w ? WLAT : RLAT;
        erd3  = (a == 2'd3) ? 8'h00 : erd;
        eerr3 = (a == 2'd3) ? 1'b1 : eerr;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        rsp_ready = (hold == 0);
        waits = 0;
        while (!(req_ready && req_ready3) && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk(nm, "accept_wait", waits, 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk(nm, "ready_low", {req_ready, req_ready3}, 2'b00);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            eop = w && (k >= 1) && (k <= 3);
            chk(nm, $sformatf("sel_c%0d", k), row_sel, exp_sel(k, w, int'(a), 4));
            chk(nm, $sformatf("sel3_c%0d", k), {1'b0, row_sel3}, exp_sel(k, w, int'(a), 3));
            chk(nm, $sformatf("op_c%0d", k), {row_op, row_op3}, {eop, eop});
            chk(nm, $sformatf("rspv_c%0d", k), {rsp_valid, rsp_valid3}, (k == lat) ? 2'b11 : 2'b00);
            if (eop) chk(nm, $sformatf("din_c%0d", k), {row_din, row_din3}, {d, d});
        end
        chk(nm, "rdata", rsp_rdata, erd);
        chk(nm, "err", rsp_err, eerr);
        chk(nm, "rdata3", rsp_rdata3, erd3);
        chk(nm, "err3", rsp_err3, eerr3);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk(nm, "hold_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, eerr, erd});
            chk(nm, "hold_ctl", {req_ready, row_sel}, 5'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk(nm, "idle_after", {rsp_valid, rsp_valid3, req_ready, req_ready3}, 4'b0011);
    endtask

    typedef struct {
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        int         hold;
        logic       stk;
        logic [7:0] rd;
        logic       err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        int         mid_rsp;

        vecs[0] = '{1'b1, 2'd1, 8'hAA, 0, 1'b0, VERIFY ? 8'hAA : 8'h00, 1'b0};
        vecs[1] = '{1'b0, 2'd1, 8'h00, 0, 1'b0, 8'hAA, 1'b0};
        vecs[2] = '{1'b1, 2'd3, 8'hCC, 0, 1'b0, VERIFY ? 8'hCC : 8'h00, 1'b0};
        vecs[3] = '{1'b0, 2'd3, 8'h00, 0, 1'b0, 8'hCC, 1'b0};
        vecs[4] = '{1'b0, 2'd1, 8'h00, 4, 1'b0, 8'hAA, 1'b0};
        vecs[5] = '{1'b1, 2'd0, 8'h5A, 0, 1'b1, 8'h00, VERIFY};

        req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_wdata = 8'h00;
        rsp_ready = 1'b0; stuck = 1'b0;
        for (int r = 0; r < 4; r++) begin
            mem[r] = 8'h00;
            exp_mem[r] = 8'h00;
        end

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset", "ready_valid", {req_ready, rsp_valid, req_ready3, rsp_valid3}, 4'b1010);
        chk("reset", "rsp", {rsp_rdata, rsp_err}, 9'h0);
        chk("reset", "rowlines", {row_sel, row_op, row_din}, 13'h0);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            stuck = vecs[i].stk;
            run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].hold, vecs[i].rd, vecs[i].err);
            if (vecs[i].w) exp_mem[vecs[i].a] = vecs[i].d;
            stuck = 1'b0;
        end

        // Reset while a write is strobing its row
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 8'h33; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid", "sel_before", row_sel, 4'b0100);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid", "lines_dropped", {row_sel, row_op, row_sel3, row_op3}, 9'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid", "after_release", {req_ready, rsp_valid, req_ready3, rsp_valid3}, 4'b1010);
        mid_rsp = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || rsp_valid3) mid_rsp++;
        end
        chk("rst_mid", "no_response", mid_rsp, 0);

        // Random traffic against the reference array; every row is written first since contents are now undefined.
        for (int i = 0; i < 44; i++) begin
            w = (i < 4) ? 1'b1 : 1'($urandom);
            a = (i < 4) ? 2'(i) : 2'($urandom_range(0, 3));
            d = 8'($urandom);
            if (w) begin
                run_txn($sformatf("rnd%0d", i), w, a, d, $urandom_range(0, 2), VERIFY ? d : 8'h00, 1'b0);
                exp_mem[a] = d;
            end else begin
                run_txn($sformatf("rnd%0d", i), w, a, d, $urandom_range(0, 2), exp_mem[a], 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
